// File: rtl/buf_cmd_pkg.sv
// Shared definitions for the buffer-executor command stream: word layout,
// opcodes and the writer FSM state encoding.
package buf_cmd_pkg;

  localparam int CMD_WIDTH = 40;

  localparam logic [7:0] OP_END      = 8'hBF;
  localparam logic [7:0] OP_NOP      = 8'h80;
  localparam logic [7:0] OP_WAIT_INT = 8'h40;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_SEALING = 2'd2;

  function automatic logic [7:0] cmd_opcode(input logic [CMD_WIDTH-1:0] word);
    return word[CMD_WIDTH-1 -: 8];
  endfunction

endpackage

// File: rtl/buf_cmd_writer.sv
// Producer end of the buffer-executor command FIFO: accepts host commands,
// never overflows the FIFO and terminates each program with an END word.
//
// Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
// cmd_ready depends only on state, FIFO occupancy and abort, never on cmd_valid.
module buf_cmd_writer
  import buf_cmd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         DATA_WIDTH = CMD_WIDTH,
  parameter logic [7:0] END_OPCODE = OP_END
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_word,
  input  logic                  seal,
  input  logic                  abort,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_write_data,
  input  logic [31:0]           fifo_data_count,
  output logic                  busy,
  output logic                  sealed,
  output logic [15:0]           prog_words,
  output logic [31:0]           words_written
);

  localparam logic [DATA_WIDTH-1:0] END_WORD = {END_OPCODE, {(DATA_WIDTH-8){1'b0}}};

  logic [1:0]            state, state_n;
  logic                  fifo_write_n;
  logic [DATA_WIDTH-1:0] fifo_write_data_n;
  logic                  sealed_n;
  logic [15:0]           prog_words_n;
  logic [31:0]           words_written_n;

  logic [32:0] est;
  logic        space_cmd;
  logic        space_end;
  logic        seal_pending;
  logic        accept;
  logic        is_end_cmd;

  // The FIFO count already includes every earlier strobe, so adding the strobe
  // in flight gives the exact occupancy; reads can only make it conservative.
  assign est       = {1'b0, fifo_data_count} + {32'd0, fifo_write};
  assign space_cmd = est < 33'(FIFO_DEPTH - 1);
  assign space_end = est < 33'(FIFO_DEPTH);

  // A seal moves straight to SEALING (after the same-cycle command, if any),
  // so the pending seal is exactly the SEALING state.
  assign seal_pending = (state == ST_SEALING);

  assign cmd_ready  = rst && ((state == ST_IDLE) || (state == ST_OPEN)) &&
                      space_cmd && !abort && !seal_pending;
  assign accept     = cmd_valid && cmd_ready;
  assign is_end_cmd = (cmd_opcode(cmd_word) == END_OPCODE);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_n           = state;
    fifo_write_n      = 1'b0;
    fifo_write_data_n = fifo_write_data;
    sealed_n          = 1'b0;
    prog_words_n      = prog_words;
    words_written_n   = words_written;

    if (abort) begin
      state_n      = ST_IDLE;
      prog_words_n = 16'd0;
    end else begin
      case (state)
        ST_IDLE, ST_OPEN: begin
          if (accept) begin
            fifo_write_n      = 1'b1;
            fifo_write_data_n = cmd_word;
            words_written_n   = words_written + 32'd1;
            if (is_end_cmd) begin
              // Host supplied its own terminator; a same-cycle seal is absorbed.
              sealed_n     = 1'b1;
              state_n      = ST_IDLE;
              prog_words_n = 16'd0;
            end else begin
              if (state == ST_IDLE) begin
                prog_words_n = 16'd1;
              end else if (prog_words != 16'hFFFF) begin
                prog_words_n = prog_words + 16'd1;
              end
              state_n = seal ? ST_SEALING : ST_OPEN;
            end
          end else if (seal) begin
            state_n = ST_SEALING;
          end
        end
        ST_SEALING: begin
          if (space_end) begin
            fifo_write_n      = 1'b1;
            fifo_write_data_n = END_WORD;
            words_written_n   = words_written + 32'd1;
            sealed_n          = 1'b1;
            state_n           = ST_IDLE;
            prog_words_n      = 16'd0;
          end
        end
        default: begin
          state_n      = ST_IDLE;
          prog_words_n = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      fifo_write      <= 1'b0;
      fifo_write_data <= '0;
      sealed          <= 1'b0;
      prog_words      <= 16'd0;
      words_written   <= 32'd0;
    end else begin
      state           <= state_n;
      fifo_write      <= fifo_write_n;
      fifo_write_data <= fifo_write_data_n;
      sealed          <= sealed_n;
      prog_words      <= prog_words_n;
      words_written   <= words_written_n;
    end
  end

endmodule

// File: doc/buf_cmd_writer.md
Name: buf_cmd_writer

Overview:
- Producer end of the buffer-executor command FIFO.
- Accepts 40-bit command words (opcode[39:32], payload[31:0]) from a host-side valid/ready source and writes them into the shared command FIFO.
- Never overflows the FIFO, using exact occupancy tracking.
- Frames each program: on request, appends the END word 40'hBF00000000 that terminates execution.

Parameters:
- FIFO_DEPTH, 16, capacity of the downstream FIFO in words.
- DATA_WIDTH, 40, command word width. Fixed at 40; other values are unsupported.
- END_OPCODE, 8'hBF, opcode of the program terminator.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low: asserted when rst=0, sampled on clk.
- cmd_valid  in  1  source presents cmd_word.
- cmd_ready  out  1  writer accepts cmd_word this cycle.
- cmd_word  in  40  command word.
- seal  in  1  single-cycle pulse; request END word for the current program.
- abort  in  1  single-cycle pulse; discard the open program state.
- fifo_write  out  1  registered write strobe to the FIFO.
- fifo_write_data  out  40  registered write data.
- fifo_data_count  in  32  FIFO occupancy; excludes a write strobed this cycle.
- busy  out  1  state != IDLE.
- sealed  out  1  one-cycle pulse when the END word is written.
- prog_words  out  16  words written in the current program, END excluded; saturates at 16'hFFFF.
- words_written  out  32  total words written since reset, END included; wraps.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - fifo_write=0, fifo_write_data=0.
  - sealed=0, prog_words=0, words_written=0.
  - cmd_ready=0 during reset.
- Occupancy estimate:
  - est = fifo_data_count + fifo_write, computed with at least 6 bits.
  - est is exact because the FIFO count includes every earlier strobe. Reads only lower it, so the estimate is conservative.
- space_cmd = est < FIFO_DEPTH-1. One slot is always reserved for END.
- space_end = est < FIFO_DEPTH.
- cmd_ready is combinational:
  - cmd_ready = (state==IDLE || state==OPEN) && space_cmd && !abort && !seal_pending.
- Accept = cmd_valid && cmd_ready. On the next cycle, fifo_write=1 and fifo_write_data=cmd_word. Latency is 1 cycle; at most one write per cycle.
- States:
  - IDLE:
    - On accept: go to OPEN, prog_words=1.
    - On seal: go to SEALING.
  - OPEN:
    - On accept: prog_words+1 (saturating).
    - On seal: go to SEALING.
  - SEALING:
    - cmd_ready=0.
    - When space_end: write END word next cycle, pulse sealed with that write, go to IDLE, prog_words=0.
- Accepted word whose opcode == END_OPCODE:
  - It is written as-is and acts as the terminator.
  - sealed pulses with its write; state goes to IDLE; prog_words=0.
  - No extra END word is generated.
- seal and accept in the same cycle:
  - The command is written first, then END; the command's write has priority.
  - seal_pending is held internally until the SEALING transition.
- seal in IDLE with no words written: an END-only (empty) program is emitted.
- seal while already SEALING: ignored; only one END is written.
- abort:
  - Highest priority.
  - Next state=IDLE; prog_words=0; seal_pending cleared; no accept that cycle.
  - A write already strobed that cycle completes; no new write is issued the following cycle.
  - words_written is retained.
- FIFO full (est==FIFO_DEPTH-1): cmd_ready=0; END is still allowed.
- FIFO at est==FIFO_DEPTH: END waits in SEALING.
- words_written increments on every fifo_write and wraps 32'hFFFFFFFF -> 0.
- Reset mid-operation: everything returns to reset values; pending END is lost.

Decomposition:
- Shared package buf_cmd_pkg:
  - opcode constants: END 8'hBF, NOP 8'h80, WAIT_INT 8'h40.
  - state encoding constants: IDLE, OPEN, SEALING.
  - width 40.
- The package is shared with buf_executor.
- No sub-module; the occupancy compare stays inline.

Test Plan:
- Basic program, FIFO drained slowly: send 8000000000, 4000000000, 8300000001, then seal.
  - Required FIFO sequence: 8000000000, 4000000000, 8300000001, BF00000000.
  - sealed pulses once; words_written=4; prog_words reaches 3 and then returns to 0.
- Backpressure, FIFO_DEPTH=16, no reads, cmd_valid held:
  - Exactly 15 words accepted; cmd_ready stays 0; no overflow.
  - seal then writes END as word 16.
  - Second seal with a full FIFO: stays SEALING until one read, then END is written one cycle later.
- Same-cycle cmd_valid with 8500000008 plus seal:
  - FIFO receives 8500000008 at N+1 and BF00000000 at N+2; sealed pulses at N+2.
- Explicit END word BF00000000 sent:
  - Written once; sealed pulses; state goes to IDLE; no duplicate END appears.
- Abort after 2 words (8808070605, 8704030201), same cycle as seal:
  - No END is written; busy=0 next cycle; prog_words=0; words_written=2.
  - A following seal emits a lone BF00000000.
- rst=0 asserted for 1 cycle while SEALING with a full FIFO:
  - All outputs return to 0; no END is written after release.
